game_flow_controller: RTL and testbench
=======================================

// Module: game_flow_controller
// PURPOSE
//  Upstream sequencer for the game top level: owns the game state machine and the timebase.
//  Generates the gated update strobes (upsig, upsig_fast), the obstacle drop strobe and the alive level.
//  Consumes the top level's colision output and the player's start button.
//  Handles crash freeze, life counting and game-over.
// PARAMETERS
//  SLOW_DIV     500000  clk cycles per slow tick (upsig rate; 100 Hz at 50 MHz)
//  FAST_DIV     250000  clk cycles per fast tick (upsig_fast rate, background scroll)
//  DROP_EVERY   64      upsig pulses between successive drop pulses (>=1)
//  CRASH_TICKS  200     slow ticks spent frozen in CRASH (>=1)
//  LIVES        3       lives at game start (1..3)
// PORTS
//  clk         in   1  system/pixel clock
//  reset       in   1  asynchronous, active-high reset
//  start       in   1  start button level, already debounced and synchronous to clk
//  colision    in   1  player/obstacle overlap level from the game top level
//  upsig       out  1  1-cycle pulse per slow tick, only while RUN
//  upsig_fast  out  1  1-cycle pulse per fast tick, only while RUN
//  drop        out  1  1-cycle pulse: request a new obstacle
//  alive       out  1  high while RUN (enables the score counter)
//  lives_left  out  2  remaining lives
//  game_state  out  2  IDLE=00, RUN=01, CRASH=10, OVER=11
// BEHAVIOUR
//  Reset (async): state=IDLE; all counters=0; lives_left=LIVES; start_q=1.
//   upsig, upsig_fast, drop and alive are all 0.
//  Prescalers: slow_cnt and fast_cnt ($clog2 width) free-run in every state.
//   tick_slow: internal 1-cycle flag when slow_cnt==SLOW_DIV-1; slow_cnt then wraps to 0 the next edge.
//   tick_fast: likewise from fast_cnt.
//   The prescalers are never cleared except by reset.
//  Start edge: start_rise = start & ~start_q; start_q <= start every cycle.
//   start_q resets to 1, so a button held through reset does not start a game.
//  All outputs are registered, computed from the current state and current-cycle inputs.
//   Latency: 1 clk from tick to pulse.
//  upsig <= tick_slow & (state==RUN) & ~colision.
//   upsig_fast <= tick_fast & (state==RUN) & ~colision.
//  drop_cnt counts upsig pulses (0..DROP_EVERY-1).
//   drop pulses in the same cycle as the upsig pulse that finds drop_cnt==DROP_EVERY-1; drop_cnt wraps to 0.
//   drop_cnt is cleared on IDLE->RUN and OVER->IDLE, and held (not cleared) through CRASH.
//  alive <= (next_state==RUN).
//   alive is therefore high exactly in the cycles where the registered game_state==RUN.
//  FSM:
//   IDLE : start_rise -> RUN; lives_left<=LIVES; drop_cnt<=0.
//   RUN  : colision=1 -> CRASH; lives_left<=lives_left-1; crash_cnt<=0.
//          start is ignored; colision has priority over every other event in RUN.
//   CRASH: colision and start are ignored; crash_cnt increments on tick_slow.
//          On the tick_slow that makes crash_cnt==CRASH_TICKS:
//            lives_left==0 -> OVER; otherwise -> RUN.
//   OVER : start_rise -> IDLE; lives_left stays 0 until the next IDLE->RUN.
//  lives_left never underflows; entry to CRASH only occurs from RUN, where lives_left>=1.
//  Reset mid-game (any state) returns to IDLE within the same cycle; no pulse is emitted afterwards.
// TESTING  (SLOW_DIV=4, FAST_DIV=2, DROP_EVERY=3, CRASH_TICKS=2, LIVES=2)
//  1. Reset with start held high, then keep start high -> state stays IDLE.
//     Release start, press it again -> RUN one cycle after the rising edge; alive=1; lives_left=2.
//  2. RUN for 40 clk with colision=0 -> upsig every 4 clk, upsig_fast every 2 clk, drop on every 3rd upsig.
//     No pulse is ever wider than 1 clk.
//  3. colision=1 for 1 clk in RUN -> state CRASH, lives_left=1, alive=0, no upsig/drop.
//     After 2 slow ticks -> RUN; drop phase resumes from the held drop_cnt.
//  4. Second colision -> CRASH with lives_left=0; after 2 slow ticks -> OVER.
//     Then start_rise -> IDLE; another start_rise -> RUN with lives_left=2.
//  5. colision asserted in the same cycle as tick_slow in RUN -> no upsig emitted; CRASH entered.
//     colision held high through all of CRASH is ignored until CRASH exits.
//  6. Assert reset mid-CRASH with crash_cnt=1 -> immediate IDLE, lives_left=2, all strobes 0, alive=0.

Source files
------------

// File: rtl/game_flow_controller.sv
// Game flow controller: owns the game state machine and the slow/fast timebase.
// Produces gated update strobes, obstacle drop requests, the alive level and
// the life count. Reacts to the start button edge and to the collision level.
module game_flow_controller #(
   parameter int unsigned SLOW_DIV    = 500000,
   parameter int unsigned FAST_DIV    = 250000,
   parameter int unsigned DROP_EVERY  = 64,
   parameter int unsigned CRASH_TICKS = 200,
   parameter int unsigned LIVES       = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       colision,
   output logic       upsig,
   output logic       upsig_fast,
   output logic       drop,
   output logic       alive,
   output logic [1:0] lives_left,
   output logic [1:0] game_state
);

   localparam int unsigned SW = (SLOW_DIV > 1)   ? $clog2(SLOW_DIV)   : 1;
   localparam int unsigned FW = (FAST_DIV > 1)   ? $clog2(FAST_DIV)   : 1;
   localparam int unsigned DW = (DROP_EVERY > 1) ? $clog2(DROP_EVERY) : 1;
   localparam int unsigned CW = $clog2(CRASH_TICKS + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      CRASH = 2'b10,
      OVER  = 2'b11
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [SW-1:0] slow_cnt;
   logic [FW-1:0] fast_cnt;
   logic [DW-1:0] drop_cnt;
   logic [CW-1:0] crash_cnt;
   logic          start_q;

   logic tick_slow;
   logic tick_fast;
   logic start_rise;
   logic up_now;
   logic fast_now;
   logic drop_last;
   logic crash_done;

   assign game_state = state;

   // Tick flags, start edge, gated strobes and next-state selection
   always_comb begin
      tick_slow  = (slow_cnt == SW'(SLOW_DIV - 1));
      tick_fast  = (fast_cnt == FW'(FAST_DIV - 1));
      start_rise = start & ~start_q;
      up_now     = tick_slow & (state == RUN) & ~colision;
      fast_now   = tick_fast & (state == RUN) & ~colision;
      drop_last  = (drop_cnt == DW'(DROP_EVERY - 1));
      crash_done = tick_slow && ((crash_cnt + CW'(1)) == CW'(CRASH_TICKS));
      next_state = state;
      case (state)
         IDLE:    if (start_rise) next_state = RUN;
         RUN:     if (colision)   next_state = CRASH;
         CRASH:   if (crash_done) next_state = (lives_left == 2'd0) ? OVER : RUN;
         OVER:    if (start_rise) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State, prescalers, counters and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         slow_cnt   <= '0;
         fast_cnt   <= '0;
         drop_cnt   <= '0;
         crash_cnt  <= '0;
         start_q    <= 1'b1;
         lives_left <= 2'(LIVES);
         upsig      <= 1'b0;
         upsig_fast <= 1'b0;
         drop       <= 1'b0;
         alive      <= 1'b0;
      end else begin
         slow_cnt   <= tick_slow ? '0 : slow_cnt + SW'(1);
         fast_cnt   <= tick_fast ? '0 : fast_cnt + FW'(1);
         start_q    <= start;
         state      <= next_state;
         upsig      <= up_now;
         upsig_fast <= fast_now;
         drop       <= up_now & drop_last;
         alive      <= (next_state == RUN);
         if (up_now) drop_cnt <= drop_last ? '0 : drop_cnt + DW'(1);
         case (state)
            IDLE: begin
               if (start_rise) begin
                  lives_left <= 2'(LIVES);
                  drop_cnt   <= '0;
               end
            end
            RUN: begin
               // up_now is low whenever colision is high, so the drop_cnt
               // update above never competes with this branch
               if (colision) begin
                  lives_left <= lives_left - 2'd1;
                  crash_cnt  <= '0;
               end
            end
            CRASH: begin
               if (tick_slow) crash_cnt <= crash_cnt + CW'(1);
            end
            OVER: begin
               if (start_rise) drop_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: the driver advances a small cycle model and
// queues the expected output on every cycle that shows a pulse or a change of
// state/alive/lives; the monitor pairs those with what the DUT shows.
module tb_game_flow_controller;

   localparam int unsigned SLOW_DIV    = 4;
   localparam int unsigned FAST_DIV    = 2;
   localparam int unsigned DROP_EVERY  = 3;
   localparam int unsigned CRASH_TICKS = 2;
   localparam int unsigned LIVES       = 2;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_CRASH = 2'b10;
   localparam logic [1:0] S_OVER  = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       colision;
   logic       upsig;
   logic       upsig_fast;
   logic       drop;
   logic       alive;
   logic [1:0] lives_left;
   logic [1:0] game_state;

   game_flow_controller #(
      .SLOW_DIV    (SLOW_DIV),
      .FAST_DIV    (FAST_DIV),
      .DROP_EVERY  (DROP_EVERY),
      .CRASH_TICKS (CRASH_TICKS),
      .LIVES       (LIVES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .colision   (colision),
      .upsig      (upsig),
      .upsig_fast (upsig_fast),
      .drop       (drop),
      .alive      (alive),
      .lives_left (lives_left),
      .game_state (game_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic       up;
      logic       fast;
      logic       drp;
      logic       alv;
      logic [1:0] lv;
      logic [1:0] st;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // model state: n is the index of the next active edge since reset release
   int         n;
   logic [1:0] m_st;
   int         m_lives;
   int         m_dcnt;
   int         m_ccnt;
   logic       m_sq;
   logic [1:0] p_st;
   logic       p_alv;
   int         p_lives;

   task automatic model_reset();
      n       = 0;
      m_st    = S_IDLE;
      m_lives = LIVES;
      m_dcnt  = 0;
      m_ccnt  = 0;
      m_sq    = 1'b1;
      p_st    = S_IDLE;
      p_alv   = 1'b0;
      p_lives = LIVES;
   endtask

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // apply inputs for one cycle and queue the expected result of that edge
   task automatic cyc(input logic s, input logic c);
      logic ts, tf, rise, eu, ef, ed, ealv;
      exp_t e;
      start    = s;
      colision = c;
      @(posedge clk);
      ts   = (n % SLOW_DIV) == SLOW_DIV - 1;
      tf   = (n % FAST_DIV) == FAST_DIV - 1;
      rise = s & ~m_sq;
      m_sq = s;
      eu   = ts && (m_st == S_RUN) && !c;
      ef   = tf && (m_st == S_RUN) && !c;
      ed   = eu && (m_dcnt == DROP_EVERY - 1);
      if (eu) m_dcnt = (m_dcnt + 1) % DROP_EVERY;
      case (m_st)
         S_IDLE:  if (rise) begin m_st = S_RUN; m_lives = LIVES; m_dcnt = 0; end
         S_RUN:   if (c) begin m_st = S_CRASH; m_lives = m_lives - 1; m_ccnt = 0; end
         S_CRASH: if (ts) begin
                     m_ccnt++;
                     if (m_ccnt == CRASH_TICKS) m_st = (m_lives == 0) ? S_OVER : S_RUN;
                  end
         default: if (rise) begin m_st = S_IDLE; m_dcnt = 0; end
      endcase
      ealv = (m_st == S_RUN);
      if (eu || ef || ed || m_st != p_st || ealv != p_alv || m_lives != p_lives) begin
         e.cyc = n; e.up = eu; e.fast = ef; e.drp = ed; e.alv = ealv;
         e.lv = 2'(m_lives); e.st = m_st;
         sb.push_back(e);
      end
      p_st = m_st; p_alv = ealv; p_lives = m_lives;
      n++;
      #2;
   endtask

   task automatic run_until(input logic [1:0] target, input logic c, input int limit);
      int k;
      k = 0;
      while (m_st != target && k < limit) begin
         cyc(1'b0, c);
         k++;
      end
      tests++;
      if (m_st != target) begin
         fails++;
         $display("FAIL run_until: model state %0d, expected %0d within %0d cycles", m_st, target, limit);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      #1;
      check("reset_state", game_state, S_IDLE);
      check("reset_lives", lives_left, 2'(LIVES));
      check("reset_upsig", {1'b0, upsig}, 2'd0);
      check("reset_fast",  {1'b0, upsig_fast}, 2'd0);
      check("reset_drop",  {1'b0, drop}, 2'd0);
      check("reset_alive", {1'b0, alive}, 2'd0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   // Monitor: pair each DUT-visible event with the queued expectation of that cycle
   logic [1:0] d_st;
   logic       d_alv;
   logic [1:0] d_lv;
   always @(negedge clk) begin : monitor
      int   cur;
      logic dut_ev;
      logic have;
      exp_t e;
      if (reset) begin
         d_st  = S_IDLE;
         d_alv = 1'b0;
         d_lv  = 2'(LIVES);
      end else begin
         cur    = n - 1;
         dut_ev = upsig | upsig_fast | drop | (game_state != d_st) |
                  (alive != d_alv) | (lives_left != d_lv);
         while (sb.size() > 0 && sb[0].cyc < cur) begin
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missed_event: cyc %0d expected up=%b fast=%b drop=%b alive=%b lives=%0d state=%0d, no output seen",
                     e.cyc, e.up, e.fast, e.drp, e.alv, e.lv, e.st);
         end
         have = (sb.size() > 0) && (sb[0].cyc == cur);
         if (dut_ev || have) begin
            tests++;
            if (!have) begin
               fails++;
               $display("FAIL unexpected_event: cyc %0d got up=%b fast=%b drop=%b alive=%b lives=%0d state=%0d, expected no change",
                        cur, upsig, upsig_fast, drop, alive, lives_left, game_state);
            end else begin
               e = sb.pop_front();
               if ({upsig, upsig_fast, drop, alive, lives_left, game_state} !==
                   {e.up, e.fast, e.drp, e.alv, e.lv, e.st}) begin
                  fails++;
                  $display("FAIL event: cyc %0d got up=%b fast=%b drop=%b alive=%b lives=%0d state=%0d, expected up=%b fast=%b drop=%b alive=%b lives=%0d state=%0d",
                           cur, upsig, upsig_fast, drop, alive, lives_left, game_state,
                           e.up, e.fast, e.drp, e.alv, e.lv, e.st);
               end
            end
         end
         d_st  = game_state;
         d_alv = alive;
         d_lv  = lives_left;
      end
   end

   initial begin
      reset    = 1'b1;
      start    = 1'b1;
      colision = 1'b0;
      @(posedge clk);
      #2;
      do_reset();

      // 1: start held through reset is not an edge; a fresh press starts the game
      repeat (5) cyc(1'b1, 1'b0);
      check("held_start_idle", game_state, S_IDLE);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);

      // 2: free running in RUN
      repeat (40) cyc(1'b0, 1'b0);

      // 3: single-cycle collision, freeze, resume
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      run_until(S_RUN, 1'b0, 20);
      repeat (16) cyc(1'b0, 1'b0);

      // 4: last life lost, game over, back to idle, new game
      cyc(1'b0, 1'b1);
      run_until(S_OVER, 1'b0, 20);
      repeat (3) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
      repeat (6) cyc(1'b0, 1'b0);

      // 5: collision coinciding with a slow tick, held through the whole freeze
      while ((n % SLOW_DIV) != SLOW_DIV - 1) cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      run_until(S_RUN, 1'b1, 20);
      repeat (8) cyc(1'b0, 1'b0);

      // 6: reset in the middle of a freeze with crash_cnt==1
      cyc(1'b0, 1'b1);
      begin
         int k;
         k = 0;
         while (m_ccnt != 1 && k < 20) begin
            cyc(1'b0, 1'b0);
            k++;
         end
      end
      check("pre_reset_model_crash", m_st, S_CRASH);
      do_reset();
      repeat (8) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (12) cyc(1'b0, 1'b0);

      @(negedge clk);
      #1;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL leftover_expectations: got %0d pending, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
